// File: rtl/clk_div_bank_if.sv
// Purpose: configuration/enable inputs and divided-clock/tick outputs of clk_div_bank.
// Latency: none (wires only).
// Backpressure: none; ConfigDuty exists only when DIV_DUTY_CFG_EN is defined.
interface clk_div_bank_if #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 32,
   parameter int SEL_W = 2
);
   logic [N_CH-1:0]  Enable;
   logic [WIDTH-1:0] Din;
   logic [SEL_W-1:0] ConfigSel;
   logic             ConfigDiv;
`ifdef DIV_DUTY_CFG_EN
   logic             ConfigDuty;
`endif
   logic             Sync;
   logic [N_CH-1:0]  ClkOut;
   logic [N_CH-1:0]  Tick;

`ifdef DIV_DUTY_CFG_EN
   modport master (output Enable, Din, ConfigSel, ConfigDiv, ConfigDuty, Sync,
                   input  ClkOut, Tick);
   modport slave  (input  Enable, Din, ConfigSel, ConfigDiv, ConfigDuty, Sync,
                   output ClkOut, Tick);
`else
   modport master (output Enable, Din, ConfigSel, ConfigDiv, Sync,
                   input  ClkOut, Tick);
   modport slave  (input  Enable, Din, ConfigSel, ConfigDiv, Sync,
                   output ClkOut, Tick);
`endif
endinterface

// File: rtl/clk_div_bank.sv
// Purpose: N_CH programmable clock-enable dividers with shadowed divisor (and high count under DIV_DUTY_CFG_EN), Sync realign.
// Latency: 1 cycle from Enable/Sync to registered ClkOut/Tick; config writes apply at the next period boundary.
// Backpressure: none; channels free-run, writes are always accepted, out-of-range ConfigSel is dropped.
module clk_div_bank #(
   parameter int          N_CH    = 4,
   parameter int          WIDTH   = 32,
   parameter int          SEL_W   = 2,
   parameter int unsigned DEF_DIV = 2
) (
   input logic           Clk,
   input logic           ResetN,
   clk_div_bank_if.slave bus
);
   localparam logic [WIDTH-1:0] DEF_T = WIDTH'(DEF_DIV);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
`ifdef DIV_DUTY_CFG_EN
   localparam logic [WIDTH-1:0] DEF_H = DEF_T >> 1;
`endif

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [N_CH-1:0] clk_out_q;
   logic [N_CH-1:0] tick_q;

   assign bus.ClkOut = clk_out_q;
   assign bus.Tick   = tick_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           state, state_nxt;
      logic [WIDTH-1:0] ts, ts_byp;
      logic [WIDTH-1:0] ta, ta_nxt, te;
      logic [WIDTH-1:0] cnt, cnt_nxt;
      logic [WIDTH-1:0] high_nxt;
      logic             wr_div;
      logic             clk_nxt, tick_nxt;

      // A shadow written in the same cycle it is loaded hands over the new Din.
      assign wr_div = bus.ConfigDiv && (bus.ConfigSel == SEL_W'(g));
      assign ts_byp = wr_div ? bus.Din : ts;
      // A divisor of 0 behaves as 1 so the period never collapses.
      assign te     = (ta == '0) ? ONE : ta;

`ifdef DIV_DUTY_CFG_EN
      logic [WIDTH-1:0] hs, hs_byp;
      logic [WIDTH-1:0] ha, ha_nxt;
      logic             wr_duty;

      assign wr_duty  = bus.ConfigDuty && (bus.ConfigSel == SEL_W'(g));
      assign hs_byp   = wr_duty ? bus.Din : hs;
      assign high_nxt = ha_nxt;
`else
      logic [WIDTH-1:0] te_nxt;

      // High time is half the period, forced high when the period is a single cycle.
      assign te_nxt   = (ta_nxt == '0) ? ONE : ta_nxt;
      assign high_nxt = (te_nxt == ONE) ? ONE : (te_nxt >> 1);
`endif

      // Next-state: start/stop, period wrap or Sync restart, and active-setting reload at boundaries.
      always_comb begin
         state_nxt = state;
         ta_nxt    = ta;
         cnt_nxt   = cnt;
`ifdef DIV_DUTY_CFG_EN
         ha_nxt    = ha;
`endif
         case (state)
            IDLE: begin
               cnt_nxt = '0;
               if (bus.Enable[g]) begin
                  state_nxt = RUN;
                  ta_nxt    = ts_byp;
`ifdef DIV_DUTY_CFG_EN
                  ha_nxt    = hs_byp;
`endif
               end
            end
            RUN: begin
               if (!bus.Enable[g]) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if ((cnt == te - ONE) || bus.Sync) begin
                  cnt_nxt = '0;
                  ta_nxt  = ts_byp;
`ifdef DIV_DUTY_CFG_EN
                  ha_nxt  = hs_byp;
`endif
               end else begin
                  cnt_nxt = cnt + ONE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Outputs are derived from next-state values so they register with no input-to-output path.
      always_comb begin
         clk_nxt  = 1'b0;
         tick_nxt = 1'b0;
         if (state_nxt == RUN) begin
            clk_nxt  = (cnt_nxt < high_nxt);
            tick_nxt = (cnt_nxt == '0);
         end
      end

      // State register: synchronous reset restores default divisor and idles the channel.
      always_ff @(posedge Clk) begin
         if (!ResetN) begin
            state        <= IDLE;
            ts           <= DEF_T;
            ta           <= DEF_T;
            cnt          <= '0;
            clk_out_q[g] <= 1'b0;
            tick_q[g]    <= 1'b0;
`ifdef DIV_DUTY_CFG_EN
            hs           <= DEF_H;
            ha           <= DEF_H;
`endif
         end else begin
            state        <= state_nxt;
            ts           <= ts_byp;
            ta           <= ta_nxt;
            cnt          <= cnt_nxt;
            clk_out_q[g] <= clk_nxt;
            tick_q[g]    <= tick_nxt;
`ifdef DIV_DUTY_CFG_EN
            hs           <= hs_byp;
            ha           <= ha_nxt;
`endif
         end
      end
   end : g_ch
endmodule

// File: tb/tb_clk_div_bank.sv
// Purpose: self-checking bench for clk_div_bank; a cycle model fills a scoreboard queue, each edge is popped and compared.
// Latency: expectations describe the outputs visible one edge after the inputs are applied.
// Backpressure: none; the bench drives every input each cycle.
module tb_clk_div_bank;
   localparam int N_CH    = 4;
   localparam int WIDTH   = 32;
   localparam int SEL_W   = 3;
   localparam int DEF_DIV = 2;

   typedef struct packed {
      logic [N_CH-1:0] clk_out;
      logic [N_CH-1:0] tick;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_vec;
   int   n_err;

   // Reference model: period position, active and shadow settings per channel.
   int m_run[N_CH];
   int m_ph [N_CH];
   int m_ta [N_CH];
   int m_ha [N_CH];
   int m_ts [N_CH];
   int m_hs [N_CH];

   clk_div_bank_if #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

   clk_div_bank #(
      .N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W), .DEF_DIV(DEF_DIV)
   ) dut (
      .Clk(clk),
      .ResetN(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int eff(input int t);
      return (t == 0) ? 1 : t;
   endfunction

   // Advance the model by one edge using the inputs currently driven and queue the outputs it predicts.
   function automatic void model_push();
      exp_t e;
      int   ts_b, hs_b, high, per;
      e = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         ts_b = m_ts[ch];
         hs_b = m_hs[ch];
         if (bus.ConfigDiv && int'(bus.ConfigSel) == ch) ts_b = int'(bus.Din);
`ifdef DIV_DUTY_CFG_EN
         if (bus.ConfigDuty && int'(bus.ConfigSel) == ch) hs_b = int'(bus.Din);
`endif
         if (!rst_n) begin
            m_ts[ch] = DEF_DIV;  m_hs[ch] = DEF_DIV / 2;
            m_ta[ch] = DEF_DIV;  m_ha[ch] = DEF_DIV / 2;
            m_run[ch] = 0;       m_ph[ch] = 0;
         end else begin
            m_ts[ch] = ts_b;
            m_hs[ch] = hs_b;
            if (m_run[ch] == 0) begin
               if (bus.Enable[ch]) begin
                  m_run[ch] = 1; m_ph[ch] = 0; m_ta[ch] = ts_b; m_ha[ch] = hs_b;
               end
            end else if (!bus.Enable[ch]) begin
               m_run[ch] = 0; m_ph[ch] = 0;
            end else if (bus.Sync || m_ph[ch] == eff(m_ta[ch]) - 1) begin
               m_ph[ch] = 0; m_ta[ch] = ts_b; m_ha[ch] = hs_b;
            end else begin
               m_ph[ch] = m_ph[ch] + 1;
            end
         end
         per = eff(m_ta[ch]);
`ifdef DIV_DUTY_CFG_EN
         high = m_ha[ch];
`else
         high = (per == 1) ? 1 : per / 2;
`endif
         e.clk_out[ch] = (m_run[ch] != 0) && (m_ph[ch] < high);
         e.tick[ch]    = (m_run[ch] != 0) && (m_ph[ch] == 0);
      end
      sb.push_back(e);
   endfunction

   task automatic clear_cfg();
      bus.ConfigDiv = 1'b0;
`ifdef DIV_DUTY_CFG_EN
      bus.ConfigDuty = 1'b0;
`endif
      bus.Sync = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         rst_n = (i >= 3);
         bus.Enable = '0;
         clear_cfg();
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL reset cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
      end
   endtask

   task automatic test_defaults();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         bus.Enable = 4'b0001;
         clear_cfg();
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL defaults cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
      end
   endtask

   // Channel 1 starts at T=2, then is reprogrammed to T=5 (high 2) mid-period.
   task automatic test_reload();
      exp_t e;
      for (int i = 0; i < 22; i++) begin
         bus.Enable = 4'b0011;
         clear_cfg();
         bus.ConfigSel = 3'd1;
         bus.ConfigDiv = (i == 3);
`ifdef DIV_DUTY_CFG_EN
         bus.ConfigDuty = (i == 4);
`endif
         bus.Din = (i == 3) ? 32'd5 : 32'd2;
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL reload cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
      end
   endtask

   // Channel 2 walks through divisor 0, 1, high>=period, high=0 and an odd period.
   task automatic test_edge_div();
      exp_t e;
      int   div_tab [5] = '{0, 1, 4, 4, 7};
      int   duty_tab[5] = '{1, 1, 7, 0, 3};
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 12; i++) begin
            bus.Enable = 4'b0111;
            clear_cfg();
            bus.ConfigSel = 3'd2;
            bus.ConfigDiv = (i == 0);
`ifdef DIV_DUTY_CFG_EN
            bus.ConfigDuty = (i == 1);
`endif
            bus.Din = (i == 0) ? 32'(div_tab[k]) : 32'(duty_tab[k]);
            model_push();
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
               n_err++;
               $display("FAIL edge_div T=%0d cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                        div_tab[k], i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
            end
         end
      end
   endtask

   // Channels at T=3, 4, 7, 7 drift out of phase, an out-of-range write is dropped, then Sync realigns them.
   task automatic test_sync();
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         bus.Enable = 4'b1111;
         clear_cfg();
         bus.ConfigDiv = (i <= 3) || (i == 14);
`ifdef DIV_DUTY_CFG_EN
         bus.ConfigDuty = (i == 14);
`endif
         case (i)
            0:       begin bus.ConfigSel = 3'd0; bus.Din = 32'd3; end
            1:       begin bus.ConfigSel = 3'd1; bus.Din = 32'd4; end
            2:       begin bus.ConfigSel = 3'd3; bus.Din = 32'd7; end
            3:       begin bus.ConfigSel = 3'd2; bus.Din = 32'd7; end
            default: begin bus.ConfigSel = 3'd7; bus.Din = 32'd9; end
         endcase
         bus.Sync = (i == 20);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL sync cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
         if (i == 20) begin
            n_vec++;
            if (bus.Tick !== 4'b1111) begin
               n_err++;
               $display("FAIL sync_align: Tick=%b, wanted 1111", bus.Tick);
            end
         end
      end
   endtask

   task automatic test_disable();
      exp_t e;
      for (int i = 0; i < 14; i++) begin
         bus.Enable = (i >= 2 && i < 5) ? 4'b1101 : 4'b1111;
         clear_cfg();
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL disable cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
      end
   endtask

   // Channel 3 at T=6 is reset mid-period; afterwards every channel runs at the default divisor.
   task automatic test_mid_reset();
      exp_t e;
      for (int i = 0; i < 22; i++) begin
         bus.Enable = 4'b1111;
         clear_cfg();
         bus.ConfigSel = 3'd3;
         bus.ConfigDiv = (i == 0);
         bus.Din = 32'd6;
         rst_n = (i != 11);
         model_push();
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (bus.ClkOut !== e.clk_out || bus.Tick !== e.tick) begin
            n_err++;
            $display("FAIL mid_reset cyc%0d: ClkOut=%b Tick=%b, wanted ClkOut=%b Tick=%b",
                     i, bus.ClkOut, bus.Tick, e.clk_out, e.tick);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.Enable = '0;
      bus.Din = '0;
      bus.ConfigSel = '0;
      clear_cfg();
      for (int ch = 0; ch < N_CH; ch++) begin
         m_run[ch] = 0; m_ph[ch] = 0;
         m_ta[ch] = DEF_DIV; m_ha[ch] = DEF_DIV / 2;
         m_ts[ch] = DEF_DIV; m_hs[ch] = DEF_DIV / 2;
      end
      test_reset();
      test_defaults();
      test_reload();
      test_edge_div();
      test_sync();
      test_disable();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock divider and successor to the single-channel divider. It provides N_CH independent, fully synchronous divided-clock and tick outputs from one system clock. Each channel's divisor, and optionally its high time, is configured through a shared write port. New settings take effect glitch-free at the channel's next period boundary, and a Sync strobe phase-aligns all channels. Its outputs feed peripheral timing (baud, PWM, sample strobes) as clock enables; they are not used as clock nets.

## Interface
- N_CH, 4: number of divider channels.
- WIDTH, 32: divisor/high-count width in bits.
- SEL_W, 2: width of ConfigSel; must satisfy 2**SEL_W >= N_CH.
- DEF_DIV, 2: divisor loaded into every channel at reset.
- Clk  input  1  system clock; all state changes on its rising edge.
- ResetN  input  1  synchronous active-low reset, sampled on the rising edge of Clk.
- Enable  input  N_CH  per-channel run enable.
- Din  input  WIDTH  configuration write data.
- ConfigSel  input  SEL_W  channel addressed by a write.
- ConfigDiv  input  1  write Din to the selected channel's shadow divisor.
- ConfigDuty  input  1  write Din to the selected channel's shadow high count (present only with DIV_DUTY_CFG_EN).
- Sync  input  1  restart the period of all enabled channels.
- ClkOut  output  N_CH  registered divided clock per channel.
- Tick  output  N_CH  registered one-cycle pulse in the first cycle of each period.

## Operation
- Per channel state:
  - shadow divisor Ts and shadow high count Hs;
  - active divisor Ta and active high count Ha;
  - counter cnt (WIDTH bits);
  - state IDLE or RUN.
- Reset (ResetN=0 at an edge):
  - Ts=Ta=DEF_DIV and Hs=Ha=DEF_DIV>>1;
  - cnt=0, state IDLE;
  - ClkOut=0, Tick=0 on all channels.
- Writes:
  - ConfigDiv=1 sets Ts[ConfigSel]<=Din; ConfigDuty=1 sets Hs[ConfigSel]<=Din.
  - ConfigSel >= N_CH is ignored.
  - Writes never modify Ta/Ha directly.
- Effective divisor: Te = max(Ta,1), so a Din of 0 is treated as 1.
- IDLE state:
  - Enable=1 moves the channel to RUN and loads Ta<=Ts, Ha<=Hs, cnt<=0 at the same edge.
- RUN state:
  - Enable=0 moves the channel to IDLE at that edge, with cnt<=0, ClkOut<=0, Tick<=0. This takes priority over Sync and period wrap.
  - Otherwise, if cnt==Te-1 or Sync=1: cnt<=0 and Ta<=Ts, Ha<=Hs (a period boundary).
  - Otherwise cnt<=cnt+1.
- Registered outputs, written as each edge's next-state values:
  - ClkOut <= (cnt_next < Ha_next);
  - Tick <= (cnt_next == 0) while in RUN.
- Resulting waveform: ClkOut is high for the first Ha cycles of each Te-cycle period, and Tick marks cycle 0 of each period.
- Edge cases:
  - Ha >= Te gives ClkOut constant 1.
  - Ha = 0 gives ClkOut constant 0.
  - Te = 1 gives ClkOut=1 (if Ha>=1) and Tick=1 every cycle.
- Write bypass: if a channel loads from its shadow register in the same cycle that register is written, the new Din is loaded.
- Arithmetic: all comparisons are unsigned, WIDTH bits wide. cnt never exceeds Te-1, so no wrap is possible.

## Timing
- Enable rise sampled at edge k: Tick=1 and ClkOut=(Hs>0) are visible after edge k, and cnt=0 in that cycle. Latency is 1 cycle.
- Enable fall sampled at edge k: ClkOut=0 and Tick=0 after edge k.
- A config write at edge k takes effect at the first period boundary after edge k. The running period is never truncated or stretched, except by Sync.
- Sync sampled at edge k: every channel in RUN shows cnt=0 and Tick=1 after edge k. A channel entering RUN at the same edge also starts at cnt=0, so it is aligned.
- ResetN=0 mid-operation overrides every other input at that edge.
- There are no combinational paths from inputs to outputs.

## Configuration
- DIV_DUTY_CFG_EN defined:
  - ConfigDuty port and the Hs/Ha registers exist;
  - high time is programmable per channel as described above.
- DIV_DUTY_CFG_EN undefined:
  - ConfigDuty port, Hs and Ha are removed;
  - Ha is replaced everywhere by Te>>1, which gives floor(T/2) high cycles (a 50% duty cycle for even T, and low-biased for odd T);
  - for Te=1, ClkOut is forced to 1.

## Test plan
- Reset, then Enable[0]=1 with defaults: ClkOut[0] toggles 1,0,1,0 (DEF_DIV=2); Tick[0] is high every 2nd cycle starting in the first enabled cycle; all other channels stay 0.
- Write Ts[1]=5 (and Hs[1]=2 when DIV_DUTY_CFG_EN) while channel 1 is running at T=2: the current period completes, then ClkOut[1] runs 1,1,0,0,0 repeating with Tick[1] once per 5 cycles. Without the macro the pattern is 1,1,0,0,0 (high count 5>>1=2).
- Divisors 0 and 1 on channel 2: ClkOut[2]=1 and Tick[2]=1 every cycle. Hs=7 with Ts=4: ClkOut constant 1. Hs=0: ClkOut constant 0.
- Channels at T=3, 4 and 7 running out of phase, then pulse Sync: all Tick bits are 1 in the cycle after Sync, and periods repeat aligned from there. Also check ConfigSel=7 with N_CH=4 leaves all shadows unchanged.
- ResetN=0 mid-period on a T=6 channel: after that edge ClkOut=Tick=0 and the shadows return to DEF_DIV. Enable=0 in the middle of a period gives outputs 0 after the next edge, and re-enabling restarts at cnt=0.
